// File: rtl/spell_sram_bridge.sv
// Adapts single-byte code/data requests to 32-bit wishbone word cycles, with a
// one-entry write-through word cache and an ack timeout.
module spell_sram_bridge #(
  parameter logic [7:0]  BASE_WORD = 8'h00,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        invalidate,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic        req_space,
  input  logic [7:0]  req_addr,
  input  logic [7:0]  req_wdata,
  output logic        ready,
  output logic [7:0]  rdata,
  output logic        err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [7:0]  wb_addr_o,
  output logic [31:0] wb_dat_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i,
  output logic [1:0]  state_o
);

  // Handshake: req_* fields are held stable with req_valid until the one-cycle
  // ready pulse; a new request is accepted only once req_valid has been seen low.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] dat_q, dat_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        armed_q, armed_d;
  logic        cache_valid_q, cache_valid_d;
  logic [7:0]  cache_tag_q, cache_tag_d;
  logic [31:0] cache_data_q, cache_data_d;
  logic [7:0]  req_word;

  assign req_word = BASE_WORD + {1'b0, req_space, req_addr[7:2]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cyc_q         <= 1'b0;
      we_q          <= 1'b0;
      sel_q         <= 4'h0;
      addr_q        <= 8'h00;
      dat_q         <= 32'h0;
      lane_q        <= 2'd0;
      cnt_q         <= 8'h00;
      ready_q       <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= 8'h00;
      armed_q       <= 1'b1;
      cache_valid_q <= 1'b0;
      cache_tag_q   <= 8'h00;
      cache_data_q  <= 32'h0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      we_q          <= we_d;
      sel_q         <= sel_d;
      addr_q        <= addr_d;
      dat_q         <= dat_d;
      lane_q        <= lane_d;
      cnt_q         <= cnt_d;
      ready_q       <= ready_d;
      err_q         <= err_d;
      rdata_q       <= rdata_d;
      armed_q       <= armed_d;
      cache_valid_q <= cache_valid_d;
      cache_tag_q   <= cache_tag_d;
      cache_data_q  <= cache_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    we_d          = we_q;
    sel_d         = sel_q;
    addr_d        = addr_q;
    dat_d         = dat_q;
    lane_d        = lane_q;
    cnt_d         = cnt_q;
    ready_d       = 1'b0;
    err_d         = 1'b0;
    rdata_d       = rdata_q;
    armed_d       = armed_q | ~req_valid;
    cache_valid_d = cache_valid_q;
    cache_tag_d   = cache_tag_q;
    cache_data_d  = cache_data_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && armed_q) begin
          armed_d = 1'b0;
          if (!enable) begin
            ready_d = 1'b1;
            rdata_d = 8'h00;
            state_d = S_DONE;
          end else if (!req_write && cache_valid_q && (cache_tag_q == req_word)) begin
            ready_d = 1'b1;
            rdata_d = cache_data_q[{req_addr[1:0], 3'b000} +: 8];
            state_d = S_DONE;
          end else begin
            state_d = S_BUS;
            cyc_d   = 1'b1;
            we_d    = req_write;
            addr_d  = req_word;
            lane_d  = req_addr[1:0];
            cnt_d   = 8'h00;
            if (req_write) begin
              sel_d = 4'b0001 << req_addr[1:0];
              dat_d = {4{req_wdata}};
            end else begin
              sel_d = 4'hF;
            end
          end
        end
      end

      S_BUS: begin
        // Ack is checked first so a same-cycle ack beats the timeout.
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          ready_d = 1'b1;
          state_d = S_DONE;
          if (!we_q) begin
            rdata_d       = wb_dat_i[{lane_q, 3'b000} +: 8];
            cache_valid_d = 1'b1;
            cache_tag_d   = addr_q;
            cache_data_d  = wb_dat_i;
          end else if (cache_tag_q == addr_q) begin
            cache_data_d[{lane_q, 3'b000} +: 8] = dat_q[7:0];
          end
        end else if (cnt_q == TIMEOUT_CNT) begin
          cyc_d   = 1'b0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = 8'hFF;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Invalidation overrides a fill landing in the same cycle.
    if (invalidate || !enable) cache_valid_d = 1'b0;
  end

  assign ready     = ready_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign wb_sel_o  = sel_q;
  assign wb_addr_o = addr_q;
  assign wb_dat_o  = dat_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_spell_sram_bridge.sv
// Directed and randomized stimulus against a word-level memory/cache reference
// model; a second instance covers the BASE_WORD address wrap.
module tb_spell_sram_bridge;
  localparam int T_OUT = 4;
  localparam int BASE0 = 0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, enable, invalidate, req_valid, req_write, req_space;
  logic [7:0]  req_addr, req_wdata;
  logic        ready, err;
  logic [7:0]  rdata;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [7:0]  wb_addr_o;
  logic [31:0] wb_dat_o;
  logic        wb_ack_i;
  logic [31:0] wb_dat_i;
  logic [1:0]  dbg_state;

  logic        enable_b, invalidate_b, req_valid_b, req_write_b, req_space_b;
  logic [7:0]  req_addr_b, req_wdata_b;
  logic        ready_b, err_b;
  logic [7:0]  rdata_b;
  logic        cyc_b, stb_b, we_b;
  logic [3:0]  sel_b;
  logic [7:0]  addr_b;
  logic [31:0] dat_o_b;
  logic        ack_b;
  logic [31:0] dat_i_b;
  logic [1:0]  state_b;
  logic [7:0]  seen_addr_b;

  spell_sram_bridge #(.BASE_WORD(8'h00), .TIMEOUT(T_OUT)) u_dut (
    .clock(clock), .reset(reset), .enable(enable), .invalidate(invalidate),
    .req_valid(req_valid), .req_write(req_write), .req_space(req_space),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .ready(ready), .rdata(rdata), .err(err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o),
    .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i), .state_o(dbg_state)
  );

  spell_sram_bridge #(.BASE_WORD(8'hFF), .TIMEOUT(T_OUT)) u_dut_wrap (
    .clock(clock), .reset(reset), .enable(enable_b), .invalidate(invalidate_b),
    .req_valid(req_valid_b), .req_write(req_write_b), .req_space(req_space_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .ready(ready_b), .rdata(rdata_b), .err(err_b),
    .wb_cyc_o(cyc_b), .wb_stb_o(stb_b), .wb_we_o(we_b),
    .wb_sel_o(sel_b), .wb_addr_o(addr_b), .wb_dat_o(dat_o_b),
    .wb_ack_i(ack_b), .wb_dat_i(dat_i_b), .state_o(state_b)
  );

  int errors = 0;
  int checks = 0;

  // RAM and bus monitor state
  logic [31:0] mem [256];
  int          ack_delay = 0;
  bit          no_ack = 0;
  bit          late_ack = 0;
  int          wait_cnt = 0;
  int          bus_count, cyc_cycles, stab_bad;
  logic [7:0]  bus_addr;
  logic [3:0]  bus_sel;
  logic        bus_we;
  logic [31:0] bus_dat;
  logic        prev_cyc = 1'b0;

  // Reference model: memory contents and which word the cache holds
  logic [31:0] ref_mem [256];
  bit          ref_valid = 0;
  logic [7:0]  ref_tag = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    wb_ack_i = 1'b0;
    wb_dat_i = 32'h0;
    bus_count = 0; cyc_cycles = 0; stab_bad = 0;
    forever begin
      @(posedge clock); #1;
      if (wb_cyc_o) begin
        cyc_cycles++;
        if (!prev_cyc) begin
          bus_count++;
          bus_addr = wb_addr_o; bus_sel = wb_sel_o; bus_we = wb_we_o; bus_dat = wb_dat_o;
        end else if (wb_addr_o !== bus_addr || wb_sel_o !== bus_sel ||
                     wb_we_o !== bus_we || wb_dat_o !== bus_dat) begin
          stab_bad++;
        end
        if (wb_stb_o !== 1'b1) stab_bad++;
        if (!no_ack && wait_cnt == ack_delay) begin
          wb_ack_i = 1'b1;
          wait_cnt = 0;
          if (wb_we_o) begin
            for (int i = 0; i < 4; i++)
              if (wb_sel_o[i]) mem[wb_addr_o][i*8 +: 8] = wb_dat_o[i*8 +: 8];
          end else begin
            wb_dat_i = mem[wb_addr_o];
          end
        end else begin
          wb_ack_i = 1'b0;
          wait_cnt++;
        end
      end else begin
        wb_ack_i = late_ack;
        wait_cnt = 0;
        wb_dat_i = $urandom;
      end
      prev_cyc = wb_cyc_o;
    end
  end

  initial begin
    ack_b = 1'b0;
    dat_i_b = 32'h11223344;
    seen_addr_b = 8'h00;
    forever begin
      @(posedge clock); #1;
      if (cyc_b) begin
        ack_b = 1'b1;
        seen_addr_b = addr_b;
      end else begin
        ack_b = 1'b0;
      end
    end
  end

  task automatic pulse_invalidate();
    @(negedge clock); invalidate = 1'b1;
    @(negedge clock); invalidate = 1'b0;
    ref_valid = 0;
  endtask

  task automatic run_req(input bit w, input bit sp, input logic [7:0] a,
                         input logic [7:0] wd, input int hold);
    int word, lane, exp_lat, exp_cyc, lat, pulses;
    bit exp_bus, exp_err, check_rd, got;
    logic [7:0]  exp_rd, rd, rd_after;
    logic [31:0] wtmp;
    logic        er;
    word = (BASE0 + (sp ? 64 : 0) + int'(a) / 4) % 256;
    lane = int'(a) % 4;
    wtmp = ref_mem[word];
    exp_bus = 0; exp_err = 0; exp_cyc = 0; check_rd = 1; exp_rd = 8'h00;
    if (!enable) begin
      exp_lat = 1;
    end else if (!w && ref_valid && ref_tag == word[7:0]) begin
      exp_lat = 1;
      exp_rd = wtmp[lane*8 +: 8];
    end else begin
      exp_bus = 1;
      if (no_ack) begin
        exp_lat = T_OUT + 2; exp_cyc = T_OUT + 1; exp_err = 1; exp_rd = 8'hFF;
      end else begin
        exp_lat = ack_delay + 2; exp_cyc = ack_delay + 1;
        check_rd = !w;
        exp_rd = wtmp[lane*8 +: 8];
      end
    end

    @(negedge clock);
    bus_count = 0; cyc_cycles = 0; stab_bad = 0;
    req_valid = 1'b1; req_write = w; req_space = sp; req_addr = a; req_wdata = wd;
    lat = 0; got = 0; pulses = 0; rd = 8'h00; er = 1'b0;
    while (!got && lat < 400) begin
      @(posedge clock); #1;
      lat++;
      if (ready) begin
        got = 1; pulses = 1; rd = rdata; er = err;
      end
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      if (ready) pulses++;
      req_addr = req_addr + 8'd4;
    end
    req_valid = 1'b0;
    @(posedge clock); #1;
    if (ready) pulses++;
    rd_after = rdata;

    chk("ready_seen", 32'(got), 1);
    chk("latency", lat, exp_lat);
    chk("err", 32'(er), 32'(exp_err));
    if (check_rd) chk("rdata", rd, exp_rd);
    chk("ready_pulses", pulses, 1);
    chk("bus_cycles", bus_count, 32'(exp_bus));
    chk("rdata_hold", rd_after, rd);
    if (exp_bus) begin
      chk("wb_addr", bus_addr, word);
      chk("wb_sel", bus_sel, w ? (32'd1 << lane) : 32'hF);
      chk("wb_we", bus_we, 32'(w));
      if (w) chk("wb_dat", bus_dat, {4{wd}});
      chk("cyc_cycles", cyc_cycles, exp_cyc);
      chk("bus_stable", stab_bad, 0);
    end

    if (enable && exp_bus && !no_ack) begin
      if (w) begin
        wtmp[lane*8 +: 8] = wd;
        ref_mem[word] = wtmp;
      end else begin
        ref_valid = 1;
        ref_tag = word[7:0];
      end
    end
  endtask

  initial begin
    int lat_b;
    reset = 1'b1; enable = 1'b1; invalidate = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_space = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    enable_b = 1'b1; invalidate_b = 1'b0; req_valid_b = 1'b0; req_write_b = 1'b0;
    req_space_b = 1'b0; req_addr_b = 8'h00; req_wdata_b = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[2] = 32'hDDCCBBAA; ref_mem[2] = 32'hDDCCBBAA;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_ctl", {ready, err, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, rdata, wb_addr_o, dbg_state}, 0);
    chk("reset_dat", wb_dat_o, 0);
    @(negedge clock); reset = 1'b0;

    // Read miss then hit on word 2
    ack_delay = 0;
    run_req(0, 0, 8'h09, 8'h00, 0);
    run_req(0, 0, 8'h0B, 8'h00, 0);
    chk("hit_value", rdata, 8'hDD);

    // Write-through lane update on the cached code word 0x42
    ack_delay = 1;
    run_req(0, 1, 8'h08, 8'h00, 0);
    run_req(1, 1, 8'h0A, 8'h5A, 0);
    chk("write_addr", bus_addr, 8'h42);
    chk("write_sel", bus_sel, 4'b0100);
    chk("write_dat", bus_dat, 32'h5A5A5A5A);
    run_req(0, 1, 8'h0A, 8'h00, 0);
    chk("write_hit", rdata, 8'h5A);

    // Timeout, then the same word still misses
    no_ack = 1;
    run_req(0, 0, 8'h0C, 8'h00, 0);
    no_ack = 0;
    ack_delay = 0;
    run_req(0, 0, 8'h0C, 8'h00, 0);

    // Ack arriving on the timeout cycle is honoured
    ack_delay = T_OUT;
    run_req(0, 0, 8'h30, 8'h00, 0);
    ack_delay = 0;

    // Disabled path
    @(negedge clock); enable = 1'b0; ref_valid = 0;
    run_req(0, 1, 8'h0A, 8'h00, 0);
    run_req(1, 1, 8'h0A, 8'h77, 0);
    @(negedge clock); enable = 1'b1;
    run_req(0, 1, 8'h0A, 8'h00, 0);

    // Invalidate pulse forces the next read to the bus
    pulse_invalidate();
    run_req(0, 1, 8'h0A, 8'h00, 0);

    // Held request yields a single bus cycle
    ack_delay = 2;
    run_req(0, 0, 8'h40, 8'h00, 3);
    ack_delay = 0;

    // Reset while a bus cycle is in flight
    run_req(0, 0, 8'h20, 8'h00, 0);
    no_ack = 1;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_space = 1'b0; req_addr = 8'h24;
    repeat (2) @(posedge clock);
    #1;
    chk("bus_before_reset", wb_cyc_o, 1);
    @(negedge clock); reset = 1'b1; req_valid = 1'b0;
    @(posedge clock); #1;
    chk("mid_reset_ctl", {ready, err, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, rdata, wb_addr_o, dbg_state}, 0);
    chk("mid_reset_dat", wb_dat_o, 0);
    @(negedge clock); reset = 1'b0; no_ack = 0; ref_valid = 0;
    late_ack = 1'b1;
    @(negedge clock); late_ack = 1'b0;
    @(posedge clock); #1;
    chk("late_ack_ready", ready, 0);
    chk("late_ack_cyc", wb_cyc_o, 0);
    run_req(0, 0, 8'h20, 8'h00, 0);

    // Randomized mix
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) pulse_invalidate();
      ack_delay = $urandom_range(0, 3);
      run_req($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 2));
    end

    // BASE_WORD wrap on the second instance
    @(negedge clock);
    req_valid_b = 1'b1; req_space_b = 1'b1; req_addr_b = 8'h04;
    lat_b = 0;
    while (!ready_b && lat_b < 50) begin
      @(posedge clock); #1;
      lat_b++;
    end
    chk("wrap_ready", ready_b, 1);
    chk("wrap_addr", seen_addr_b, 8'h40);
    chk("wrap_rdata", rdata_b, 8'h44);
    chk("wrap_latency", lat_b, 2);
    req_valid_b = 1'b0;
    repeat (2) @(posedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
